// File: rtl/mult_booth_ctrl.sv
// Radix-4 Booth multiplier with a valid/ready request side and a held result.
// One partial product is accumulated per BUSY cycle. The multiplicand is shifted left
// by two and the multiplier right by two each step, so no barrel shifter is needed.
module mult_booth_ctrl #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned STEPS = WIDTH / 2 + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_src1,
  input  logic [WIDTH-1:0] i_src2,
  input  logic             i_flush,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [WIDTH-1:0] o_result
);

  localparam int unsigned AccW  = 2 * WIDTH;
  localparam int unsigned YW    = WIDTH + 3;  // extended multiplier plus y[-1]
  localparam int unsigned CntW  = $clog2(STEPS + 1);
  localparam int unsigned WordW = (WIDTH < 32) ? WIDTH : 32;

  localparam logic [2:0] OpMul    = 3'b000;
  localparam logic [2:0] OpMulh   = 3'b001;
  localparam logic [2:0] OpMulhsu = 3'b010;
  localparam logic [2:0] OpMulhu  = 3'b011;
  localparam logic [2:0] OpMulw   = 3'b100;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [AccW-1:0]   acc_q, acc_d;
  logic [AccW-1:0]   x_q, x_d;
  logic [YW-1:0]     y_q, y_d;

  logic [2:0]        op_n;
  logic              sx, sy;
  logic              neg;
  logic [AccW-1:0]   mag;
  logic [AccW-1:0]   pp;

  // Normalise the opcode and pick operand signedness.
  always_comb begin
    op_n = (i_op > OpMulw) ? OpMul : i_op;
    sx   = (op_n != OpMulhu) && i_src1[WIDTH-1];
    sy   = (op_n != OpMulhu) && (op_n != OpMulhsu) && i_src2[WIDTH-1];
  end

  // Booth digit decode of the current low triplet into a signed partial product.
  always_comb begin
    neg = 1'b0;
    mag = '0;
    case (y_q[2:0])
      3'b001, 3'b010: mag = x_q;
      3'b011:         mag = x_q << 1;
      3'b100: begin
        mag = x_q << 1;
        neg = 1'b1;
      end
      3'b101, 3'b110: begin
        mag = x_q;
        neg = 1'b1;
      end
      default:        mag = '0;
    endcase
    pp = neg ? ~mag : mag;
  end

  // Next-state logic; flush overrides accept, stepping and result handshake.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    x_d     = x_q;
    y_d     = y_q;
    if (i_flush) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (i_valid) begin
            op_d    = op_n;
            cnt_d   = '0;
            acc_d   = '0;
            x_d     = {{WIDTH{sx}}, i_src1};
            y_d     = {sy, sy, i_src2, 1'b0};
            state_d = StBusy;
          end
        end
        StBusy: begin
          acc_d = acc_q + pp + {{(AccW - 1){1'b0}}, neg};
          x_d   = x_q << 2;
          y_d   = y_q >> 2;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(STEPS - 1)) state_d = StDone;
        end
        StDone: begin
          if (i_res_ready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      op_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // Handshake flags and result selection; result is forced to zero outside DONE.
  always_comb begin
    o_ready     = (state_q == StIdle);
    o_res_valid = (state_q == StDone);
    o_result    = '0;
    if (state_q == StDone) begin
      case (op_q)
        OpMulh, OpMulhsu, OpMulhu: o_result = acc_q[AccW-1:WIDTH];
        OpMulw: begin
          for (int i = 0; i < int'(WIDTH); i++) begin
            o_result[i] = (i < int'(WordW)) ? acc_q[i] : acc_q[WordW-1];
          end
        end
        default: o_result = acc_q[WIDTH-1:0];
      endcase
    end
  end

endmodule

// File: tb/tb_mult_booth_ctrl.sv
// Directed and random checks of mult_booth_ctrl against a plain-product reference.
module tb_mult_booth_ctrl;

  localparam int W     = 64;
  localparam int STEPS = W / 2 + 1;

  logic         i_clk;
  logic         i_rst_n;
  logic         i_valid;
  logic         o_ready;
  logic [2:0]   i_op;
  logic [W-1:0] i_src1;
  logic [W-1:0] i_src2;
  logic         i_flush;
  logic         o_res_valid;
  logic         i_res_ready;
  logic [W-1:0] o_result;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] sb_q[$];

  mult_booth_ctrl #(.WIDTH(W)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_op        (i_op),
    .i_src1      (i_src1),
    .i_src2      (i_src2),
    .i_flush     (i_flush),
    .o_res_valid (o_res_valid),
    .i_res_ready (i_res_ready),
    .o_result    (o_result)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Reference: full-width product of the extended operands, then per-op selection.
  function automatic logic [W-1:0] ref_res(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [2*W-1:0] ax, bx, p;
    logic sa, sb;
    sa = (op != 3'b011);
    sb = (op != 3'b011) && (op != 3'b010);
    ax = (sa && a[W-1]) ? {{W{1'b1}}, a} : {{W{1'b0}}, a};
    bx = (sb && b[W-1]) ? {{W{1'b1}}, b} : {{W{1'b0}}, b};
    p  = ax * bx;
    case (op)
      3'b001, 3'b010, 3'b011: return p[2*W-1:W];
      3'b100:                 return {{(W-32){p[31]}}, p[31:0]};
      default:                return p[W-1:0];
    endcase
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {1'b0, {(W-1){1'b1}}};
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  // Present a request in IDLE; operands are scrambled right after acceptance.
  task automatic accept(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp);
    chk("ready_before_accept", {63'b0, o_ready}, 64'd1);
    i_valid = 1'b1;
    i_op    = op;
    i_src1  = a;
    i_src2  = b;
    @(posedge i_clk);
    #1;
    sb_q.push_back(exp);
    i_valid = 1'b0;
    i_op    = 3'($urandom());
    i_src1  = {$urandom(), $urandom()};
    i_src2  = {$urandom(), $urandom()};
  endtask

  // Wait for the result, check latency and value, optionally stall before the handshake.
  task automatic finish_op(input int hold);
    int lat;
    logic [W-1:0] exp;
    lat = 0;
    while (!o_res_valid && lat < 100) begin
      @(posedge i_clk);
      #1;
      lat++;
      if (lat == 1) begin
        chk("result_zero_busy", o_result, '0);
        chk("ready_low_busy", {63'b0, o_ready}, 64'd0);
      end
    end
    chk("latency", 64'(lat), 64'(STEPS));
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 'x;
    chk("result", o_result, exp);
    if (hold > 0) begin
      i_valid = 1'b1;
      i_op    = 3'b000;
      i_src1  = 64'd5;
      i_src2  = 64'd6;
    end
    for (int k = 0; k < hold; k++) begin
      @(posedge i_clk);
      #1;
      chk("bp_result_stable", o_result, exp);
      chk("bp_valid_held", {63'b0, o_res_valid}, 64'd1);
      chk("bp_ready_low", {63'b0, o_ready}, 64'd0);
    end
    i_res_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_res_ready = 1'b0;
    i_valid     = 1'b0;
    chk("post_hs_valid_low", {63'b0, o_res_valid}, 64'd0);
    chk("post_hs_idle", {63'b0, o_ready}, 64'd1);
    chk("post_hs_result_zero", o_result, '0);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input int hold);
    accept(op, a, b, exp);
    finish_op(hold);
  endtask

  initial begin
    logic [2:0]   op;
    logic [W-1:0] a, b;
    int seen;

    i_rst_n     = 1'b0;
    i_valid     = 1'b0;
    i_op        = '0;
    i_src1      = '0;
    i_src2      = '0;
    i_flush     = 1'b0;
    i_res_ready = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_ready", {63'b0, o_ready}, 64'd1);
    chk("rst_res_valid", {63'b0, o_res_valid}, 64'd0);
    chk("rst_result", o_result, '0);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Directed vectors.
    run_op(3'b000, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB, 0);
    run_op(3'b001, '1, '1, 64'h0, 0);
    run_op(3'b011, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    run_op(3'b010, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op(3'b100, 64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 10);
    run_op(3'b111, 64'd12345, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_CFC7, 0);

    // Flush at step 15 with a simultaneous request.
    accept(3'b000, 64'd100, 64'd200, 64'd20000);
    repeat (15) @(posedge i_clk);
    #1;
    i_flush = 1'b1;
    i_valid = 1'b1;
    i_src1  = 64'd9;
    i_src2  = 64'd9;
    @(posedge i_clk);
    #1;
    i_flush = 1'b0;
    i_valid = 1'b0;
    if (sb_q.size() != 0) void'(sb_q.pop_back());
    chk("flush_ready", {63'b0, o_ready}, 64'd1);
    chk("flush_res_valid", {63'b0, o_res_valid}, 64'd0);
    seen = 0;
    for (int k = 0; k < STEPS + 5; k++) begin
      @(posedge i_clk);
      #1;
      if (o_res_valid || !o_ready) seen++;
    end
    chk("flush_stays_idle", 64'(seen), 64'd0);
    run_op(3'b011, 64'hDEAD_BEEF_0123_4567, 64'h8000_0000_0000_0001,
           ref_res(3'b011, 64'hDEAD_BEEF_0123_4567, 64'h8000_0000_0000_0001), 0);

    // Reset mid-operation, with flush and valid also asserted.
    accept(3'b001, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h3FFF_FFFF_FFFF_FFFF);
    repeat (10) @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    i_valid = 1'b1;
    i_flush = 1'b1;
    @(posedge i_clk);
    #1;
    if (sb_q.size() != 0) void'(sb_q.pop_back());
    chk("midrst_ready", {63'b0, o_ready}, 64'd1);
    chk("midrst_res_valid", {63'b0, o_res_valid}, 64'd0);
    chk("midrst_result", o_result, '0);
    i_rst_n = 1'b1;
    i_valid = 1'b0;
    i_flush = 1'b0;
    @(posedge i_clk);
    #1;
    chk("after_rst_idle", {63'b0, o_ready}, 64'd1);
    run_op(3'b001, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h3FFF_FFFF_FFFF_FFFF, 0);

    // Random mix of ops and corner operands.
    for (int n = 0; n < 250; n++) begin
      op = 3'($urandom());
      a  = pick_operand();
      b  = pick_operand();
      run_op(op, a, b, ref_res(op, a, b), (n % 50 == 0) ? 3 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
